// File: rtl/rsa_sign_arbiter.sv
// -----------------------------------------------------------------------------
// rsa_sign_arbiter
//
// Shares one RSA signing engine among NUM_REQ requesters. Arbitration is
// round-robin: the most recent winner has the lowest priority in the next
// arbitration. The winning requester's hash and partial-key mode are
// registered towards the engine. A one-cycle start pulse launches the job.
// The engine's signature is captured on completion and returned to the
// owner with a one-cycle resp_valid pulse.
//
// Job flow: IDLE -> ISSUE -> WAIT -> RESP -> IDLE
//
// Optional feature (compile-time macro):
//   RSA_SIGN_TIMEOUT_EN - builds a WAIT watchdog. It aborts a job after
//                         TIMEOUT_CYCLES engine-busy cycles. The aborted job
//                         gets resp_error=1 and an all-zero signature. With
//                         the macro undefined there is no counter, and
//                         resp_error is tied low.
//
// Parameters:
//   NUM_REQ         number of requesters (2..8)
//   TIMEOUT_CYCLES  WAIT-cycle limit before abort (timeout build only)
//
// Ports:
//   clk             clock, rising edge
//   reset           asynchronous, active-high reset
//   req             per-requester request level, held until resp_valid
//   req_partial     per-requester threshold (partial-key) mode select
//   req_hash        per-requester 128-bit hash, requester i at [128*i +: 128]
//   grant           one-hot engine owner, zero when idle
//   eng_start       one-cycle start pulse to the engine
//   eng_partial     mode to the engine, registered at grant
//   eng_hash        hash to the engine, registered at grant
//   eng_done        engine completion pulse (honoured only in WAIT)
//   eng_signature   engine result, valid with eng_done
//   resp_valid      one-cycle one-hot completion pulse to the owner
//   resp_signature  captured signature, stable until the next capture
//   resp_error      high with resp_valid when the job timed out
//   busy            high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module rsa_sign_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [NUM_REQ-1:0]     req_partial,
    input  logic [NUM_REQ*128-1:0] req_hash,
    output logic [NUM_REQ-1:0]     grant,
    output logic                   eng_start,
    output logic                   eng_partial,
    output logic [127:0]           eng_hash,
    input  logic                   eng_done,
    input  logic [255:0]           eng_signature,
    output logic [NUM_REQ-1:0]     resp_valid,
    output logic [255:0]           resp_signature,
    output logic                   resp_error,
    output logic                   busy
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // Reject configurations outside the supported range at elaboration.
    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 2) begin : g_bad_param
        $error("rsa_sign_arbiter: unsupported NUM_REQ or TIMEOUT_CYCLES");
    end

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    state_t               state_q;
    logic [IDX_W-1:0]     rrPtr_q;
    logic [NUM_REQ-1:0]   grant_q;
    logic                 engStart_q;
    logic                 engPartial_q;
    logic [127:0]         engHash_q;
    logic [NUM_REQ-1:0]   respValid_q;
    logic [255:0]         respSig_q;

`ifdef RSA_SIGN_TIMEOUT_EN
    localparam int               CNT_W       = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] TIMEOUT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] timeoutCnt_q;
    logic             respError_q;
`endif

    // Round-robin winner selection.
    logic                 winValid;
    logic [IDX_W-1:0]     winIdx;
    logic [IDX_W-1:0]     candIdx;
    logic [NUM_REQ-1:0]   winOh;
    logic [127:0]         winHash;
    logic                 winPartial;

    // The search starts just after the previous winner and wraps around.
    // The first asserted request in that order wins. The previous winner is
    // visited last, which gives it the lowest priority.
    always_comb begin
        winValid   = 1'b0;
        winIdx     = '0;
        candIdx    = '0;
        winOh      = '0;
        winHash    = '0;
        winPartial = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            candIdx = IDX_W'((int'(rrPtr_q) + k) % NUM_REQ);
            if (!winValid && req[candIdx]) begin
                winValid = 1'b1;
                winIdx   = candIdx;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winIdx == IDX_W'(i)) begin
                winOh[i]   = winValid;
                winHash    = req_hash[i*128 +: 128];
                winPartial = req_partial[i];
            end
        end
    end

    // Job sequencer with registered outputs.
    // eng_start and resp_valid default low every cycle, so each is a single
    // pulse. grant, eng_hash and eng_partial are loaded only on leaving IDLE,
    // so they stay constant for the whole job. A req that drops mid-job is
    // ignored because the FSM samples req only in IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            rrPtr_q      <= IDX_W'(NUM_REQ - 1);
            grant_q      <= '0;
            engStart_q   <= 1'b0;
            engPartial_q <= 1'b0;
            engHash_q    <= '0;
            respValid_q  <= '0;
            respSig_q    <= '0;
`ifdef RSA_SIGN_TIMEOUT_EN
            timeoutCnt_q <= '0;
            respError_q  <= 1'b0;
`endif
        end else begin
            engStart_q  <= 1'b0;
            respValid_q <= '0;
            case (state_q)
                IDLE: begin
                    if (winValid) begin
                        grant_q      <= winOh;
                        engHash_q    <= winHash;
                        engPartial_q <= winPartial;
                        rrPtr_q      <= winIdx;
                        state_q      <= ISSUE;
                    end
                end
                ISSUE: begin
                    engStart_q <= 1'b1;
`ifdef RSA_SIGN_TIMEOUT_EN
                    timeoutCnt_q <= '0;
`endif
                    state_q    <= WAIT;
                end
                WAIT: begin
                    // A completion in the expiry cycle still counts as a
                    // normal result, so eng_done is tested first.
                    if (eng_done) begin
                        respSig_q   <= eng_signature;
                        respValid_q <= grant_q;
`ifdef RSA_SIGN_TIMEOUT_EN
                        respError_q <= 1'b0;
`endif
                        state_q     <= RESP;
                    end
`ifdef RSA_SIGN_TIMEOUT_EN
                    else if (timeoutCnt_q == TIMEOUT_MAX) begin
                        respSig_q   <= '0;
                        respValid_q <= grant_q;
                        respError_q <= 1'b1;
                        state_q     <= RESP;
                    end else begin
                        timeoutCnt_q <= timeoutCnt_q + 1'b1;
                    end
`endif
                end
                RESP: begin
                    grant_q <= '0;
`ifdef RSA_SIGN_TIMEOUT_EN
                    respError_q <= 1'b0;
`endif
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign grant          = grant_q;
    assign eng_start      = engStart_q;
    assign eng_partial    = engPartial_q;
    assign eng_hash       = engHash_q;
    assign resp_valid     = respValid_q;
    assign resp_signature = respSig_q;
    assign busy           = (state_q != IDLE);

`ifdef RSA_SIGN_TIMEOUT_EN
    assign resp_error = respError_q;
`else
    assign resp_error = 1'b0;
`endif

endmodule

// File: tb/tb_rsa_sign_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rsa_sign_arbiter
//
// Directed, table-driven bench for rsa_sign_arbiter (NUM_REQ=4,
// TIMEOUT_CYCLES=16). Table entries describe one job each. Each entry gives
// the request and mode masks, the engine delay, the signature byte and the
// hand-computed winner. Separate sequences cover reset behaviour, fairness,
// a request rising in the RESP cycle, reset mid-job and the timeout
// watchdog (or its absence).
// -----------------------------------------------------------------------------
module tb_rsa_sign_arbiter;

    localparam int NUM_REQ        = 4;
    localparam int TIMEOUT_CYCLES = 16;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [NUM_REQ-1:0]     req;
    logic [NUM_REQ-1:0]     req_partial;
    logic [NUM_REQ*128-1:0] req_hash;
    logic [NUM_REQ-1:0]     grant;
    logic                   eng_start;
    logic                   eng_partial;
    logic [127:0]           eng_hash;
    logic                   eng_done;
    logic [255:0]           eng_signature;
    logic [NUM_REQ-1:0]     resp_valid;
    logic [255:0]           resp_signature;
    logic                   resp_error;
    logic                   busy;

    int checks   = 0;
    int failures = 0;

    logic [7:0] hashByte [NUM_REQ] = '{8'h5A, 8'h11, 8'h22, 8'h33};

    typedef struct {
        logic [3:0] reqMask;
        logic [3:0] partialMask;
        int         delay;
        logic [7:0] sigByte;
        int         expIdx;
        bit         dropEarly;
    } vec_t;

    vec_t vecs [6];

    rsa_sign_arbiter #(
        .NUM_REQ        (NUM_REQ),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .req            (req),
        .req_partial    (req_partial),
        .req_hash       (req_hash),
        .grant          (grant),
        .eng_start      (eng_start),
        .eng_partial    (eng_partial),
        .eng_hash       (eng_hash),
        .eng_done       (eng_done),
        .eng_signature  (eng_signature),
        .resp_valid     (resp_valid),
        .resp_signature (resp_signature),
        .resp_error     (resp_error),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    // Advance one clock. Inputs are driven and outputs sampled 1 ns after
    // the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] hashOf(input int idx);
        return {16{hashByte[idx]}};
    endfunction

    task automatic checkOutput(input string name, input logic [255:0] actual,
                               input logic [255:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] reqMask, input logic [3:0] partialMask);
        req         = reqMask;
        req_partial = partialMask;
    endtask

    task automatic doReset();
        reset         = 1'b1;
        req           = '0;
        req_partial   = '0;
        eng_done      = 1'b0;
        eng_signature = '0;
        step();
        step();
        reset = 1'b0;
        step();
    endtask

    // One complete job. The task starts and ends in IDLE, 1 ns after an edge.
    task automatic runJob(input vec_t v, input bit holdReq, input string tag);
        logic [3:0]   expOh  = 4'(1) << v.expIdx;
        logic [255:0] expSig = {32{v.sigByte}};
        applyStimulus(v.reqMask, v.partialMask);
        step();
        checkOutput({tag, " grant"}, grant, expOh);
        checkOutput({tag, " eng_partial"}, eng_partial, v.partialMask[v.expIdx]);
        checkOutput({tag, " eng_hash"}, eng_hash, hashOf(v.expIdx));
        checkOutput({tag, " start early"}, eng_start, 1'b0);
        step();
        checkOutput({tag, " eng_start"}, eng_start, 1'b1);
        if (v.dropEarly) req = '0;
        for (int c = 1; c < v.delay; c++) step();
        if (v.delay > 1) checkOutput({tag, " start pulse width"}, eng_start, 1'b0);
        checkOutput({tag, " resp early"}, resp_valid, 4'b0000);
        checkOutput({tag, " grant held"}, grant, expOh);
        eng_done      = 1'b1;
        eng_signature = expSig;
        step();
        eng_done      = 1'b0;
        eng_signature = ~expSig;
        checkOutput({tag, " resp_valid"}, resp_valid, expOh);
        checkOutput({tag, " resp_signature"}, resp_signature, expSig);
        checkOutput({tag, " resp_error"}, resp_error, 1'b0);
        checkOutput({tag, " hash held"}, eng_hash, hashOf(v.expIdx));
        if (!holdReq) req = '0;
        step();
        checkOutput({tag, " resp pulse width"}, resp_valid, 4'b0000);
        checkOutput({tag, " grant cleared"}, grant, 4'b0000);
        checkOutput({tag, " idle busy"}, busy, 1'b0);
        checkOutput({tag, " sig stable"}, resp_signature, expSig);
    endtask

    initial begin
        bit   seen;
        vec_t fv;

        req_hash = {hashOf(3), hashOf(2), hashOf(1), hashOf(0)};

        // Winners assume rr_ptr=3 after reset and follow the rotation by hand.
        vecs[0] = '{4'b0010, 4'b0010, 10, 8'hAB, 1, 1'b0};
        vecs[1] = '{4'b1001, 4'b0000,  3, 8'h5C, 3, 1'b0};
        vecs[2] = '{4'b1001, 4'b1001,  2, 8'h71, 0, 1'b0};
        vecs[3] = '{4'b0110, 4'b0100,  4, 8'h96, 1, 1'b0};
        vecs[4] = '{4'b0110, 4'b0100,  5, 8'hE2, 2, 1'b1};
        vecs[5] = '{4'b0001, 4'b0000,  1, 8'h3D, 0, 1'b0};

        doReset();
        checkOutput("reset grant", grant, 4'b0000);
        checkOutput("reset busy", busy, 1'b0);
        checkOutput("reset eng_start", eng_start, 1'b0);
        checkOutput("reset resp_valid", resp_valid, 4'b0000);
        checkOutput("reset resp_signature", resp_signature, 256'h0);
        checkOutput("reset eng_hash", eng_hash, 128'h0);
        checkOutput("reset eng_partial", eng_partial, 1'b0);
        checkOutput("reset resp_error", resp_error, 1'b0);

        // A stray eng_done while IDLE must not start anything.
        eng_done = 1'b1;
        step();
        eng_done = 1'b0;
        checkOutput("stray done busy", busy, 1'b0);
        checkOutput("stray done resp", resp_valid, 4'b0000);

        for (int i = 0; i < 6; i++) begin
            runJob(vecs[i], 1'b0, $sformatf("vec%0d", i));
        end

        // Fairness: all requests held for eight jobs.
        doReset();
        for (int j = 0; j < 8; j++) begin
            fv = '{4'b1111, 4'b1010, 2 + j, 8'h40 + 8'(j), j % 4, 1'b0};
            runJob(fv, j < 7, $sformatf("fair%0d", j));
        end

        // req[2] rises in the RESP cycle of requester 1's job.
        req = 4'b0010;
        step();
        checkOutput("rise grant1", grant, 4'b0010);
        step();
        eng_done = 1'b1;
        step();
        eng_done = 1'b0;
        req      = 4'b0100;
        checkOutput("rise resp1", resp_valid, 4'b0010);
        step();
        checkOutput("rise idle grant", grant, 4'b0000);
        step();
        checkOutput("rise grant2", grant, 4'b0100);
        step();
        eng_done = 1'b1;
        step();
        eng_done = 1'b0;
        req      = '0;
        checkOutput("rise resp2", resp_valid, 4'b0100);
        step();

        // Reset in WAIT followed by a stray eng_done.
        req = 4'b0001;
        step();
        step();
        step();
        reset = 1'b1;
        #1;
        checkOutput("midreset grant", grant, 4'b0000);
        checkOutput("midreset busy", busy, 1'b0);
        req = '0;
        step();
        reset    = 1'b0;
        eng_done = 1'b1;
        eng_signature = {32{8'h99}};
        step();
        eng_done = 1'b0;
        checkOutput("postreset resp", resp_valid, 4'b0000);
        checkOutput("postreset grant", grant, 4'b0000);
        checkOutput("postreset busy", busy, 1'b0);
        step();
        checkOutput("postreset resp later", resp_valid, 4'b0000);
        checkOutput("postreset sig", resp_signature, 256'h0);

`ifdef RSA_SIGN_TIMEOUT_EN
        // Engine never responds: abort after 16 WAIT cycles.
        req = 4'b0001;
        step();
        checkOutput("tmo grant", grant, 4'b0001);
        step();
        seen = 1'b0;
        for (int c = 0; c < 15; c++) begin
            step();
            if (resp_valid != 4'b0000) seen = 1'b1;
        end
        checkOutput("tmo no early resp", seen, 1'b0);
        step();
        checkOutput("tmo resp_valid", resp_valid, 4'b0001);
        checkOutput("tmo resp_error", resp_error, 1'b1);
        checkOutput("tmo signature", resp_signature, 256'h0);
        req = '0;
        step();
        checkOutput("tmo error cleared", resp_error, 1'b0);
        checkOutput("tmo busy", busy, 1'b0);

        // eng_done in the 16th WAIT cycle wins over expiry.
        req = 4'b0010;
        step();
        checkOutput("tmo race grant", grant, 4'b0010);
        step();
        for (int c = 0; c < 15; c++) step();
        eng_done      = 1'b1;
        eng_signature = {32{8'hC3}};
        step();
        eng_done = 1'b0;
        req      = '0;
        checkOutput("tmo race resp", resp_valid, 4'b0010);
        checkOutput("tmo race error", resp_error, 1'b0);
        checkOutput("tmo race sig", resp_signature, {32{8'hC3}});
        step();
`else
        // Without the watchdog a job waits indefinitely for eng_done.
        req = 4'b0001;
        step();
        checkOutput("nowd grant", grant, 4'b0001);
        step();
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            step();
            if (resp_valid != 4'b0000 || !busy) seen = 1'b1;
        end
        checkOutput("nowd still waiting", seen, 1'b0);
        eng_done      = 1'b1;
        eng_signature = {32{8'hC3}};
        step();
        eng_done = 1'b0;
        req      = '0;
        checkOutput("nowd resp", resp_valid, 4'b0001);
        checkOutput("nowd error", resp_error, 1'b0);
        checkOutput("nowd sig", resp_signature, {32{8'hC3}});
        step();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/rsa_sign_arbiter.md
RSA_SIGN_ARBITER -- requirements
Module: rsa_sign_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters sharing one signing engine (2..8).
REQ-002 Parameter TIMEOUT_CYCLES, default 4096, maximum engine busy cycles before abort (used only with RSA_SIGN_TIMEOUT_EN).
REQ-003 Port clk  input  1  clock; all logic SHALL be on the rising edge.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port req  input  NUM_REQ  per-requester signing request, level, held until resp_valid.
REQ-006 Port req_partial  input  NUM_REQ  per-requester threshold (partial-key) mode select.
REQ-007 Port req_hash  input  NUM_REQ*128  per-requester message hash; requester i uses bits [128*i+127:128*i].
REQ-008 Port grant  output  NUM_REQ  one-hot owner of the engine, zero when idle.
REQ-009 Port eng_start  output  1  one-cycle start pulse to the signing engine.
REQ-010 Port eng_partial  output  1  mode to engine, registered at grant.
REQ-011 Port eng_hash  output  128  hash to engine, registered at grant.
REQ-012 Port eng_done  input  1  engine completion pulse.
REQ-013 Port eng_signature  input  256  engine result, valid with eng_done.
REQ-014 Port resp_valid  output  NUM_REQ  one-cycle one-hot completion pulse to the owner.
REQ-015 Port resp_signature  output  256  captured signature, stable from resp_valid until the next capture.
REQ-016 Port resp_error  output  1  high with resp_valid when the job timed out.
REQ-017 Port busy  output  1  high in any state other than IDLE.

Function
REQ-018 FSM states SHALL be IDLE, ISSUE, WAIT, RESP.
REQ-019 IDLE: if any req bit is high, select the winner round-robin starting at index rr_ptr+1 (mod NUM_REQ), register grant, eng_hash and eng_partial from that requester, go to ISSUE; otherwise stay.
REQ-020 After each selection, rr_ptr SHALL take the winner index; the winner has lowest priority next arbitration.
REQ-021 ISSUE: assert eng_start for exactly one cycle, clear timeout counter, go to WAIT.
REQ-022 WAIT: on eng_done, capture eng_signature into resp_signature, resp_error=0, go to RESP.
REQ-023 eng_done outside WAIT SHALL be ignored.
REQ-024 RESP: pulse resp_valid at the granted bit for one cycle, then clear grant and return to IDLE.
REQ-025 Minimum latency SHALL be req high in IDLE -> grant +1 cycle, eng_start +2, resp_valid 1 cycle after the eng_done cycle.
REQ-026 Dropping req during ISSUE/WAIT SHALL NOT abort the job; the response is still issued.
REQ-027 A requester whose req remains high in the RESP cycle SHALL be treated as a new request in the next IDLE.
REQ-028 grant, eng_hash and eng_partial SHALL remain constant from ISSUE through RESP.

Reset
REQ-029 Reset SHALL force IDLE, rr_ptr=NUM_REQ-1 (so requester 0 wins first), and all outputs to zero.
REQ-030 Reset mid-job SHALL drop the job without a resp_valid; an eng_done arriving after reset release SHALL be ignored.

Configuration
REQ-031 Macro RSA_SIGN_TIMEOUT_EN defined: the WAIT counter increments each cycle; when it reaches TIMEOUT_CYCLES-1 without eng_done, the FSM goes to RESP with resp_error=1 and resp_signature=0.
REQ-032 eng_done in the same cycle as timeout expiry SHALL win (normal completion).
REQ-033 Macro undefined: no counter is built, WAIT lasts until eng_done, and resp_error is tied 0.

Verification
REQ-034 Single request: req=4'b0010, hash=0x11..11, partial=1; engine done after 10 cycles with sig=0xAB..AB -> grant=0010, eng_partial=1, resp_valid=0010 carrying 0xAB..AB, resp_error=0.
REQ-035 Fairness: req=4'b1111 held for 8 jobs after reset -> grant order 0,1,2,3,0,1,2,3.
REQ-036 Simultaneous events: req[2] rises in the RESP cycle of requester 1's job -> requester 2 is granted in the next IDLE cycle.
REQ-037 Timeout (macro on, TIMEOUT_CYCLES=16): engine never responds -> resp_valid after 16 WAIT cycles, resp_error=1, signature 0; with eng_done on cycle 16 -> resp_error=0.
REQ-038 Reset mid-WAIT followed by a stray eng_done -> no resp_valid, grant=0, busy=0.
